// File: rtl/alu_pkg.sv
// Shared definitions for the ALU front-end: op codes and sequencer state encoding.
package alu_pkg;

  localparam logic [1:0] ALU_OP_AND = 2'b00;
  localparam logic [1:0] ALU_OP_OR  = 2'b01;
  localparam logic [1:0] ALU_OP_ADD = 2'b10;
  localparam logic [1:0] ALU_OP_SUB = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Valid/ready front-end that drives a combinational ALU, waits ALU_LATENCY edges,
// then returns the sampled result and zero flag over a response handshake.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int word_length = 8,
  parameter int ALU_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [word_length-1:0] req_a,
  input  logic [word_length-1:0] req_b,
  input  logic [1:0]             req_op,
  output logic [word_length-1:0] alu_a,
  output logic [word_length-1:0] alu_b,
  output logic [1:0]             alu_control,
  input  logic [word_length:0]   alu_c,
  input  logic                   alu_zero,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [word_length:0]   rsp_c,
  output logic                   rsp_zero,
  output logic [1:0]             rsp_op,
  output logic [15:0]            op_count,
  output logic [15:0]            zero_count
);

  if (ALU_LATENCY < 1) begin : gBadLatency
    $error("alu_op_sequencer: ALU_LATENCY must be at least 1");
  end

  localparam int CNT_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

  logic [1:0]             state_q,    state_d;
  logic [CNT_W-1:0]       waitCnt_q,  waitCnt_d;
  logic [word_length-1:0] aluA_q,     aluA_d;
  logic [word_length-1:0] aluB_q,     aluB_d;
  logic [1:0]             aluCtrl_q,  aluCtrl_d;
  logic                   rspValid_q, rspValid_d;
  logic [word_length:0]   rspC_q,     rspC_d;
  logic                   rspZero_q,  rspZero_d;
  logic [1:0]             rspOp_q,    rspOp_d;
  logic                   opInc;
  logic                   zeroInc;

  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    aluCtrl_d  = aluCtrl_q;
    rspValid_d = rspValid_q;
    rspC_d     = rspC_q;
    rspZero_d  = rspZero_q;
    rspOp_d    = rspOp_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          aluA_d    = req_a;
          aluB_d    = req_b;
          aluCtrl_d = req_op;
          waitCnt_d = CNT_W'(ALU_LATENCY);
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        waitCnt_d = waitCnt_q - CNT_W'(1);
        // The ALU output has had ALU_LATENCY full periods to settle on this edge.
        if (waitCnt_q == CNT_W'(1)) begin
          rspC_d     = alu_c;
          rspZero_d  = alu_zero;
          rspOp_d    = aluCtrl_q;
          rspValid_d = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rspValid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      waitCnt_q  <= '0;
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluCtrl_q  <= '0;
      rspValid_q <= 1'b0;
      rspC_q     <= '0;
      rspZero_q  <= 1'b0;
      rspOp_q    <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluCtrl_q  <= aluCtrl_d;
      rspValid_q <= rspValid_d;
      rspC_q     <= rspC_d;
      rspZero_q  <= rspZero_d;
      rspOp_q    <= rspOp_d;
    end
  end

  assign opInc   = (state_q == ST_RESP) && rsp_ready;
  assign zeroInc = opInc && rspZero_q;

  sat_counter #(.WIDTH(16)) uOpCount (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (opInc),
    .count (op_count)
  );

  sat_counter #(.WIDTH(16)) uZeroCount (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (zeroInc),
    .count (zero_count)
  );

  assign req_ready   = (state_q == ST_IDLE);
  assign alu_a       = aluA_q;
  assign alu_b       = aluB_q;
  assign alu_control = aluCtrl_q;
  assign rsp_valid   = rspValid_q;
  assign rsp_c       = rspC_q;
  assign rsp_zero    = rspZero_q;
  assign rsp_op      = rspOp_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: two sequencers (latency 1 and 3) each driving a behavioural ALU, plus a narrow sat_counter.
module tb_alu_op_sequencer;

  logic clk;
  logic rst_n;
  logic rst3;

  // Latency-1 instance
  logic       reqValid, reqReady, rspValid, rspReady, rspZero, aluZero;
  logic [7:0] reqA, reqB, aluA, aluB;
  logic [1:0] reqOp, aluCtrl, rspOp;
  logic [8:0] aluC, rspC;
  logic [15:0] opCount, zeroCount;

  // Latency-3 instance
  logic       reqValid3, reqReady3, rspValid3, rspReady3, rspZero3, aluZero3;
  logic [7:0] reqA3, reqB3, aluA3, aluB3;
  logic [1:0] reqOp3, aluCtrl3, rspOp3;
  logic [8:0] aluC3, rspC3;
  logic [15:0] opCount3, zeroCount3;
  logic       ovr3;

  logic       incS;
  logic [2:0] countS;

  int testCount = 0;
  int failCount = 0;

  function automatic logic [8:0] aluModel(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      2'b10:   return {1'b0, a} + {1'b0, b};
      default: return {1'b0, a} - {1'b0, b};
    endcase
  endfunction

  always_comb begin
    aluC     = aluModel(aluA, aluB, aluCtrl);
    aluZero  = (aluC == 9'd0);
    aluC3    = ovr3 ? 9'h1AB : aluModel(aluA3, aluB3, aluCtrl3);
    aluZero3 = (aluC3 == 9'd0);
  end

  alu_op_sequencer #(.word_length(8), .ALU_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(reqValid), .req_ready(reqReady), .req_a(reqA), .req_b(reqB), .req_op(reqOp),
    .alu_a(aluA), .alu_b(aluB), .alu_control(aluCtrl), .alu_c(aluC), .alu_zero(aluZero),
    .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_c(rspC), .rsp_zero(rspZero), .rsp_op(rspOp),
    .op_count(opCount), .zero_count(zeroCount)
  );

  alu_op_sequencer #(.word_length(8), .ALU_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst3),
    .req_valid(reqValid3), .req_ready(reqReady3), .req_a(reqA3), .req_b(reqB3), .req_op(reqOp3),
    .alu_a(aluA3), .alu_b(aluB3), .alu_control(aluCtrl3), .alu_c(aluC3), .alu_zero(aluZero3),
    .rsp_valid(rspValid3), .rsp_ready(rspReady3), .rsp_c(rspC3), .rsp_zero(rspZero3), .rsp_op(rspOp3),
    .op_count(opCount3), .zero_count(zeroCount3)
  );

  sat_counter #(.WIDTH(3)) uSat (.clk(clk), .rst_n(rst_n), .inc(incS), .count(countS));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation on the latency-1 instance with the consumer always ready.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                               input logic [8:0] expC, input logic expZ);
    @(negedge clk);
    reqValid = 1'b1; reqA = a; reqB = b; reqOp = op; rspReady = 1'b1;
    checkOutput("req_ready_idle", reqReady, 1);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("alu_a_drive", aluA, a);
    checkOutput("alu_b_drive", aluB, b);
    checkOutput("alu_ctrl_drive", aluCtrl, op);
    checkOutput("req_ready_wait", reqReady, 0);
    checkOutput("rsp_valid_early", rspValid, 0);
    @(negedge clk);
    checkOutput("rsp_valid_rise", rspValid, 1);
    checkOutput("rsp_c", rspC, expC);
    checkOutput("rsp_zero", rspZero, expZ);
    checkOutput("rsp_op", rspOp, op);
    @(negedge clk);
    checkOutput("rsp_valid_clear", rspValid, 0);
    checkOutput("req_ready_back", reqReady, 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [8:0] c;
    logic       z;
  } vec_t;

  vec_t vecs[7];
  int   validSeen;

  initial begin
    vecs[0] = '{8'h0D, 8'h08, 2'b10, 9'h015, 1'b0};
    vecs[1] = '{8'h00, 8'h00, 2'b10, 9'h000, 1'b1};
    vecs[2] = '{8'hF0, 8'h3C, 2'b00, 9'h030, 1'b0};
    vecs[3] = '{8'h0F, 8'hF0, 2'b00, 9'h000, 1'b1};
    vecs[4] = '{8'h0F, 8'h30, 2'b01, 9'h03F, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 2'b10, 9'h100, 1'b0};
    vecs[6] = '{8'h05, 8'h05, 2'b11, 9'h000, 1'b1};

    rst_n = 1'b0; rst3 = 1'b0; ovr3 = 1'b0; incS = 1'b0;
    reqValid = 1'b0; reqA = '0; reqB = '0; reqOp = '0; rspReady = 1'b0;
    reqValid3 = 1'b0; reqA3 = '0; reqB3 = '0; reqOp3 = '0; rspReady3 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", reqReady, 1);
    checkOutput("rst_rsp_valid", rspValid, 0);
    checkOutput("rst_rsp_c", rspC, 0);
    checkOutput("rst_rsp_zero", rspZero, 0);
    checkOutput("rst_rsp_op", rspOp, 0);
    checkOutput("rst_alu_a", aluA, 0);
    checkOutput("rst_alu_b", aluB, 0);
    checkOutput("rst_alu_ctrl", aluCtrl, 0);
    checkOutput("rst_op_count", opCount, 0);
    checkOutput("rst_zero_count", zeroCount, 0);
    rst_n = 1'b1; rst3 = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].c, vecs[i].z);
    checkOutput("op_count_vecs", opCount, 7);
    checkOutput("zero_count_vecs", zeroCount, 3);
    checkOutput("alu_a_holds", aluA, 8'h05);

    // Back-pressure: second request waits while the first response is stalled
    @(negedge clk);
    reqValid = 1'b1; reqA = 8'hFF; reqB = 8'h01; reqOp = 2'b10; rspReady = 1'b0;
    @(negedge clk);
    reqA = 8'h05; reqB = 8'h03; reqOp = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("bp_rsp_valid", rspValid, 1);
      checkOutput("bp_rsp_c", rspC, 9'h100);
      checkOutput("bp_rsp_zero", rspZero, 0);
      checkOutput("bp_rsp_op", rspOp, 2'b10);
      checkOutput("bp_req_ready", reqReady, 0);
      checkOutput("bp_alu_a", aluA, 8'hFF);
    end
    rspReady = 1'b1;
    @(negedge clk);
    checkOutput("bp_hs_valid", rspValid, 0);
    checkOutput("bp_hs_ready", reqReady, 1);
    checkOutput("bp_no_accept", aluA, 8'hFF);
    checkOutput("bp_op_count", opCount, 8);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("bp_second_a", aluA, 8'h05);
    checkOutput("bp_second_ctrl", aluCtrl, 2'b11);
    @(negedge clk);
    checkOutput("bp_second_c", rspC, 9'h002);
    checkOutput("bp_second_valid", rspValid, 1);
    @(negedge clk);
    checkOutput("bp_op_count2", opCount, 9);
    checkOutput("bp_zero_count2", zeroCount, 3);

    // Latency 3: a change forced after E2 must be what is captured at E3
    @(negedge clk);
    reqValid3 = 1'b1; reqA3 = 8'h10; reqB3 = 8'h20; reqOp3 = 2'b10; rspReady3 = 1'b0;
    @(negedge clk);
    reqValid3 = 1'b0;
    checkOutput("l3_alu_a", aluA3, 8'h10);
    checkOutput("l3_valid_e0", rspValid3, 0);
    @(negedge clk);
    checkOutput("l3_valid_e1", rspValid3, 0);
    @(negedge clk);
    checkOutput("l3_valid_e2", rspValid3, 0);
    ovr3 = 1'b1;
    @(negedge clk);
    checkOutput("l3_valid_e3", rspValid3, 1);
    checkOutput("l3_rsp_c", rspC3, 9'h1AB);
    checkOutput("l3_rsp_zero", rspZero3, 0);
    rspReady3 = 1'b1;
    @(negedge clk);
    ovr3 = 1'b0;
    checkOutput("l3_op_count", opCount3, 1);
    checkOutput("l3_req_ready", reqReady3, 1);

    // Reset one cycle after acceptance discards the pending operation
    @(negedge clk);
    reqValid3 = 1'b1; reqA3 = 8'h03; reqB3 = 8'h04; reqOp3 = 2'b10;
    @(negedge clk);
    reqValid3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    checkOutput("mid_rst_valid", rspValid3, 0);
    checkOutput("mid_rst_ready", reqReady3, 1);
    checkOutput("mid_rst_alu_a", aluA3, 0);
    checkOutput("mid_rst_alu_b", aluB3, 0);
    checkOutput("mid_rst_ctrl", aluCtrl3, 0);
    checkOutput("mid_rst_opcnt", opCount3, 0);
    checkOutput("mid_rst_zcnt", zeroCount3, 0);
    @(negedge clk);
    rst3 = 1'b1;
    validSeen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rspValid3 === 1'b1) validSeen++;
    end
    checkOutput("mid_rst_no_rsp", validSeen, 0);
    checkOutput("mid_rst_idle", reqReady3, 1);

    // Saturation on a 3-bit counter
    checkOutput("sat_start", countS, 0);
    @(negedge clk);
    incS = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("sat_count5", countS, 5);
    repeat (5) @(negedge clk);
    checkOutput("sat_count10", countS, 7);
    incS = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("sat_hold", countS, 7);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
